// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED fade sequencer.
package led_seq_pkg;

   typedef enum logic [2:0] {Idle, Rst, Upd, Done, Abort} state_e;

   localparam int unsigned CLedCnt = 16;
   localparam int unsigned CChanW  = 8;
   localparam logic [3:0]  CSizeD  = 4'h4;
   localparam logic [3:0]  CSizeB  = 4'h1;

endpackage

// File: rtl/led_fade_step.sv
// One colour channel moved a bounded step toward its target, never overshooting.
module led_fade_step
   import led_seq_pkg::*;
(
   input  logic [CChanW-1:0] cur,
   input  logic [CChanW-1:0] tgt,
   input  logic [CChanW-1:0] step,
   output logic [CChanW-1:0] next_val
);

   logic              up;
   logic [CChanW-1:0] diff;

   always_comb begin
      up   = tgt > cur;
      diff = up ? (tgt - cur) : (cur - tgt);
      // A zero step means jump; a residual within one step snaps to target.
      if ((step == '0) || (diff <= step)) begin
         next_val = tgt;
      end else if (up) begin
         next_val = cur + step;
      end else begin
         next_val = cur - step;
      end
   end

endmodule

// File: rtl/led_fade_sequencer.sv
// Per-frame bus master: one index-reset byte read, then 16 faded colour writes to the LED PWM.
module led_fade_sequencer #(
   parameter logic [15:0] CAddrBase    = 16'h0000,
   parameter logic [23:0] CFramePeriod = 24'd100000,
   parameter logic [3:0]  CAckTimeout  = 4'd15,
   parameter logic [3:0]  CSizeD       = led_seq_pkg::CSizeD,
   parameter logic [3:0]  CSizeB       = led_seq_pkg::CSizeB
) (
   input  logic        AClkH,
   input  logic        AResetHN,
   input  logic        AClkHEn,
   input  logic        ACfgWrEn,
   input  logic [3:0]  ACfgIdx,
   input  logic [23:0] ACfgColor,
   input  logic [7:0]  ACfgStep,
   input  logic        AEnable,
   output logic [15:0] AIoAddr,
   output logic [63:0] AIoMosi,
   output logic [3:0]  AIoWrSize,
   output logic [3:0]  AIoRdSize,
   input  logic        AIoAddrAck,
   output logic        ABusy,
   output logic        AFrameDone,
   output logic        AErr
);

   import led_seq_pkg::*;

   state_e      state_q, state_d;
   logic [23:0] frame_cnt_q, frame_cnt_d;
   logic        tick;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  wait_q, wait_d;
   logic [7:0]  step_q, step_d;
   logic        err_q, err_d;
   logic        cur_we;

   logic [23:0] target_q [CLedCnt];
   logic [23:0] cur_q    [CLedCnt];
   logic [23:0] cur_sel, tgt_sel, next_color;

   assign cur_sel = cur_q[idx_q];
   assign tgt_sel = target_q[idx_q];

   for (genvar ch = 0; ch < 3; ch++) begin : g_step
      led_fade_step u_step (
         .cur      (cur_sel[ch*CChanW +: CChanW]),
         .tgt      (tgt_sel[ch*CChanW +: CChanW]),
         .step     (step_q),
         .next_val (next_color[ch*CChanW +: CChanW])
      );
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      tick        = 1'b0;
      if (!AEnable) begin
         frame_cnt_d = '0;
      end else if (frame_cnt_q == CFramePeriod - 24'd1) begin
         frame_cnt_d = '0;
         tick        = 1'b1;
      end else begin
         frame_cnt_d = frame_cnt_q + 24'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      wait_d     = wait_q;
      step_d     = step_q;
      err_d      = err_q;
      cur_we     = 1'b0;
      AIoAddr    = '0;
      AIoMosi    = '0;
      AIoWrSize  = '0;
      AIoRdSize  = '0;
      AFrameDone = 1'b0;
      unique case (state_q)
         Idle: begin
            // Ticks outside Idle fall through here unseen, so they are dropped.
            if (tick) begin
               state_d = Rst;
               err_d   = 1'b0;
               idx_d   = '0;
               wait_d  = '0;
               step_d  = ACfgStep;
            end
         end
         Rst: begin
            AIoAddr   = CAddrBase;
            AIoRdSize = CSizeB;
            if (AIoAddrAck) begin
               state_d = Upd;
               wait_d  = '0;
            end else if (wait_q == CAckTimeout) begin
               state_d = Abort;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         Upd: begin
            AIoAddr   = CAddrBase;
            AIoWrSize = CSizeD;
            AIoMosi   = {40'd0, next_color};
            if (AIoAddrAck) begin
               cur_we = 1'b1;
               wait_d = '0;
               if (idx_q == 4'(CLedCnt - 1)) begin
                  state_d = Done;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else if (wait_q == CAckTimeout) begin
               state_d = Abort;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         Done: begin
            AFrameDone = 1'b1;
            state_d    = Idle;
         end
         Abort: begin
            err_d   = 1'b1;
            state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         state_q     <= Idle;
         frame_cnt_q <= '0;
         idx_q       <= '0;
         wait_q      <= '0;
         step_q      <= '0;
         err_q       <= 1'b0;
      end else if (AClkHEn) begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         step_q      <= step_d;
         err_q       <= err_d;
      end
   end

   // Target writes land on the edge, so same-cycle bus data still uses the old target.
   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         for (int i = 0; i < CLedCnt; i++) begin
            target_q[i] <= '0;
            cur_q[i]    <= '0;
         end
      end else if (AClkHEn) begin
         if (ACfgWrEn) begin
            target_q[ACfgIdx] <= ACfgColor;
         end
         if (cur_we) begin
            cur_q[idx_q] <= next_color;
         end
      end
   end

   assign ABusy = (state_q != Idle);
   assign AErr  = err_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench: frame-by-frame vector table plus ack-latency, timeout and reset sequences.
module tb_led_fade_sequencer;

   logic        AClkH = 1'b0;
   logic        AResetHN, AClkHEn, ACfgWrEn, AEnable, AIoAddrAck;
   logic [3:0]  ACfgIdx;
   logic [23:0] ACfgColor;
   logic [7:0]  ACfgStep;
   logic [15:0] AIoAddr;
   logic [63:0] AIoMosi;
   logic [3:0]  AIoWrSize, AIoRdSize;
   logic        ABusy, AFrameDone, AErr;

   led_fade_sequencer #(.CFramePeriod(24'd64)) dut (
      .AClkH      (AClkH),
      .AResetHN   (AResetHN),
      .AClkHEn    (AClkHEn),
      .ACfgWrEn   (ACfgWrEn),
      .ACfgIdx    (ACfgIdx),
      .ACfgColor  (ACfgColor),
      .ACfgStep   (ACfgStep),
      .AEnable    (AEnable),
      .AIoAddr    (AIoAddr),
      .AIoMosi    (AIoMosi),
      .AIoWrSize  (AIoWrSize),
      .AIoRdSize  (AIoRdSize),
      .AIoAddrAck (AIoAddrAck),
      .ABusy      (ABusy),
      .AFrameDone (AFrameDone),
      .AErr       (AErr)
   );

   always #5 AClkH = ~AClkH;

   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic [63:0] data;
   } txn_t;

   typedef struct {
      logic [3:0]  led;
      logic [23:0] tgt;
      logic [7:0]  step;
      logic [23:0] exp;
   } vec_t;

   txn_t        log_q[$];
   txn_t        cur_t;
   vec_t        vecs[12];
   logic [23:0] exp_cur[16];
   bit          prev_req, req_now;
   int          wait_cnt, wr_seen, hold_err, fd_cnt;
   int          ack_delay   = 0;
   int          withhold_wr = -1;
   int          n_vec       = 0;
   int          n_err       = 0;

   // Bus responder and monitor: acks after ack_delay, logs accepted transactions.
   initial begin
      AIoAddrAck = 1'b0;
      forever begin
         @(negedge AClkH);
         if (!AResetHN) begin
            AIoAddrAck = 1'b0;
            prev_req   = 1'b0;
            wait_cnt   = 0;
            continue;
         end
         if (AFrameDone) fd_cnt++;
         if (AIoAddrAck && prev_req) begin
            log_q.push_back(cur_t);
            if (cur_t.rd != 4'd0) wr_seen = 0;
            else wr_seen++;
            prev_req = 1'b0;
            wait_cnt = 0;
         end
         req_now = (AIoRdSize != 4'd0) || (AIoWrSize != 4'd0);
         if (req_now) begin
            if (prev_req && (cur_t != {AIoAddr, AIoRdSize, AIoWrSize, AIoMosi})) hold_err++;
            cur_t      = {AIoAddr, AIoRdSize, AIoWrSize, AIoMosi};
            AIoAddrAck = (wait_cnt >= ack_delay) &&
                         !((AIoWrSize != 4'd0) && (wr_seen == withhold_wr));
            wait_cnt++;
            prev_req   = 1'b1;
         end else begin
            AIoAddrAck = 1'b0;
            prev_req   = 1'b0;
            wait_cnt   = 0;
         end
      end
   end

   task automatic tick();
      @(posedge AClkH);
      #2;
   endtask

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic [23:0] color);
      ACfgWrEn  = 1'b1;
      ACfgIdx   = idx;
      ACfgColor = color;
      tick();
      ACfgWrEn  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int fd0, input int bound);
      int n;
      n = 0;
      while ((fd_cnt == fd0) && (n < bound)) begin
         tick();
         n++;
      end
      chk({tag, " frame_done"}, 96'(fd_cnt != fd0), 96'd1);
      tick();
   endtask

   task automatic run_frame(input string tag, input int bound);
      int fd0;
      log_q.delete();
      fd0 = fd_cnt;
      wait_done(tag, fd0, bound);
   endtask

   task automatic wait_read(input string tag);
      int n;
      n = 0;
      while ((AIoRdSize == 4'd0) && (n < 200)) begin
         tick();
         n++;
      end
      chk({tag, " read_seen"}, 96'(AIoRdSize), 96'(4'h1));
   endtask

   task automatic check_frame(input string tag);
      chk({tag, " count"}, 96'(log_q.size()), 96'd17);
      for (int i = 0; i < log_q.size() && i < 17; i++) begin
         if (i == 0) begin
            chk({tag, " read"}, 96'({log_q[i].addr, log_q[i].rd, log_q[i].wr}),
                96'({16'h0000, 4'h1, 4'h0}));
         end else begin
            chk($sformatf("%s wr%0d hdr", tag, i),
                96'({log_q[i].addr, log_q[i].rd, log_q[i].wr}), 96'({16'h0000, 4'h0, 4'h4}));
            chk($sformatf("%s wr%0d data", tag, i), 96'(log_q[i].data),
                96'({40'd0, exp_cur[i-1]}));
         end
      end
   endtask

   initial begin
      bit quiet_bad;
      int fd0;
      AResetHN  = 1'b0;
      AClkHEn   = 1'b1;
      ACfgWrEn  = 1'b0;
      ACfgIdx   = '0;
      ACfgColor = '0;
      ACfgStep  = '0;
      AEnable   = 1'b1;
      for (int i = 0; i < 16; i++) exp_cur[i] = '0;

      vecs[0]  = '{4'd3,  24'hFF0000, 8'h40, 24'h400000};
      vecs[1]  = '{4'd3,  24'hFF0000, 8'h40, 24'h800000};
      vecs[2]  = '{4'd3,  24'hFF0000, 8'h40, 24'hC00000};
      vecs[3]  = '{4'd3,  24'hFF0000, 8'h40, 24'hFF0000};
      vecs[4]  = '{4'd3,  24'hFF0000, 8'h40, 24'hFF0000};
      vecs[5]  = '{4'd0,  24'h80FF20, 8'h00, 24'h80FF20};
      vecs[6]  = '{4'd0,  24'h000000, 8'h30, 24'h50CF00};
      vecs[7]  = '{4'd0,  24'h000000, 8'h30, 24'h209F00};
      vecs[8]  = '{4'd0,  24'h000000, 8'h30, 24'h006F00};
      vecs[9]  = '{4'd0,  24'h000000, 8'h80, 24'h000000};
      vecs[10] = '{4'd15, 24'h0000FF, 8'h80, 24'h000080};
      vecs[11] = '{4'd15, 24'h0000FF, 8'h80, 24'h0000FF};

      repeat (5) tick();
      chk("reset outputs", 96'({AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ABusy, AFrameDone, AErr}),
          96'd0);
      AEnable  = 1'b0;
      AResetHN = 1'b1;
      quiet_bad = 1'b0;
      repeat (1000) begin
         tick();
         if (ABusy || (AIoRdSize != 4'd0) || (AIoWrSize != 4'd0)) quiet_bad = 1'b1;
      end
      chk("disabled quiet", 96'(quiet_bad), 96'd0);

      AEnable = 1'b1;
      for (int v = 0; v < 12; v++) begin
         cfg_write(vecs[v].led, vecs[v].tgt);
         ACfgStep = vecs[v].step;
         run_frame($sformatf("vec%0d", v), 300);
         exp_cur[vecs[v].led] = vecs[v].exp;
         check_frame($sformatf("vec%0d", v));
      end

      // Timeout on the 7th write: LEDs 0..5 advance, LED 6 keeps its old value.
      for (int i = 0; i < 7; i++) cfg_write(4'(i), 24'h101010);
      ACfgStep    = 8'h08;
      withhold_wr = 6;
      log_q.delete();
      fd0 = fd_cnt;
      for (int n = 0; n < 300 && AErr !== 1'b1; n++) tick();
      chk("timeout err", 96'(AErr), 96'd1);
      tick();
      chk("timeout idle", 96'(ABusy), 96'd0);
      chk("timeout no done", 96'(fd_cnt - fd0), 96'd0);
      chk("timeout count", 96'(log_q.size()), 96'd7);
      for (int i = 1; i < log_q.size() && i < 7; i++)
         chk($sformatf("timeout wr%0d data", i), 96'(log_q[i].data),
             96'((i == 4) ? 64'h0000_0000_00F7_0808 : 64'h0000_0000_0008_0808));
      withhold_wr = -1;
      run_frame("recover", 300);
      for (int i = 0; i < 6; i++) exp_cur[i] = 24'h101010;
      exp_cur[3] = 24'hEF1010;
      exp_cur[6] = 24'h080808;
      check_frame("recover");
      chk("recover err clear", 96'(AErr), 96'd0);

      // Slow acks: bus must hold steady while waiting.
      ACfgStep  = 8'h00;
      ack_delay = 5;
      hold_err  = 0;
      for (int i = 0; i < 7; i++) exp_cur[i] = 24'h101010;
      run_frame("slow ack", 400);
      check_frame("slow ack");
      chk("slow ack hold", 96'(hold_err), 96'd0);
      chk("slow ack err", 96'(AErr), 96'd0);

      // Reset in the middle of write #10.
      ack_delay = 0;
      log_q.delete();
      wait_read("midrst");
      repeat (10) tick();
      chk("midrst in write", 96'({ABusy, AIoWrSize}), 96'({1'b1, 4'h4}));
      AResetHN = 1'b0;
      #1;
      chk("midrst outputs", 96'({AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ABusy, AFrameDone, AErr}),
          96'd0);
      repeat (3) tick();
      ACfgStep = 8'h01;
      AResetHN = 1'b1;
      for (int i = 0; i < 16; i++) exp_cur[i] = '0;
      run_frame("post reset", 300);
      check_frame("post reset");

      // Config write to the entry on the bus only affects the next frame.
      ACfgStep = 8'h00;
      log_q.delete();
      fd0 = fd_cnt;
      wait_read("inflight");
      repeat (3) tick();
      cfg_write(4'd2, 24'h123456);
      wait_done("inflight", fd0, 300);
      check_frame("inflight");
      exp_cur[2] = 24'h123456;
      run_frame("inflight next", 300);
      check_frame("inflight next");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_fade_sequencer.md
Name: led_fade_sequencer

Overview:
- Bus-master scheduler that drives the 16-LED RGB PWM peripheral over the IO bus.
- Holds a per-LED target colour table and a current colour table. Once per frame it steps each current colour toward its target.
- Each frame it issues one index-reset byte read, then 16 dword writes (LED 0..15) to the peripheral's auto-incrementing colour register.
- Sits between the CPU configuration registers and the IO bus, in place of software-driven colour updates.

Parameters:
- CAddrBase, 16'h0000, IO base address of the LED PWM peripheral.
- CFramePeriod, 24'd100000, enabled clocks between frame starts; legal range 32..2^24-1.
- CAckTimeout, 4'd15, max clocks to wait for AIoAddrAck per transaction.
- CSizeD, 4'h4, AIoWrSize code for a 32-bit write.
- CSizeB, 4'h1, AIoRdSize code for an 8-bit read.

Ports:
- AClkH  in  1  clock
- AResetHN  in  1  asynchronous active-low reset
- AClkHEn  in  1  clock enable; all state advances only when high
- ACfgWrEn  in  1  target-table write strobe
- ACfgIdx  in  4  LED index for the target write
- ACfgColor  in  24  target colour {R,G,B}
- ACfgStep  in  8  per-frame step per channel; 0 = jump directly to target
- AEnable  in  1  frame scheduling enable
- AIoAddr  out  16  bus address
- AIoMosi  out  64  write data; [23:0] colour, rest 0
- AIoWrSize  out  4  write size code; 0 when not writing
- AIoRdSize  out  4  read size code; 0 when not reading
- AIoAddrAck  in  1  transaction accepted
- ABusy  out  1  burst in progress
- AFrameDone  out  1  one-clock pulse when a burst completes
- AErr  out  1  sticky ack-timeout flag; cleared by the next frame start

Behaviour:
- Reset values: all tables 0, frame counter 0, state Idle. All outputs 0, including AIoAddr, AIoMosi and both size codes.
- Frame counter:
  - Increments on each enabled clock while AEnable=1.
  - At CFramePeriod-1 it wraps to 0 and raises a frame tick.
  - AEnable=0 holds the counter at 0.
  - A tick arriving while not Idle is dropped; it is not queued.
- State machine (all transitions qualified by AClkHEn):
  - Idle: on tick -> Rst, clear AErr, set LED index to 0.
  - Rst: drive AIoAddr=CAddrBase, AIoRdSize=CSizeB. On ack -> Upd. On timeout -> Abort.
  - Upd: compute next = step(current[idx], target[idx]) combinationally. Drive AIoAddr=CAddrBase, AIoWrSize=CSizeD, AIoMosi[23:0]=next.
    - On ack: current[idx] <= next. If idx=15 -> Done, else idx+1 and stay in Upd.
    - On timeout -> Abort.
  - Done: pulse AFrameDone one clock -> Idle.
  - Abort: set AErr, drive sizes 0 -> Idle. No AFrameDone. Current entries already acked keep their new values.
- Bus hold rule: address, data and size are held stable until ack. They are zero in Idle, Done and Abort.
- Timeout: the per-transaction wait counter resets on each new transaction. Timeout fires when the counter reaches CAckTimeout without ack.
- Step rule, per 8-bit channel:
  - d = |t - c|.
  - If step=0 or d <= step, then next = t.
  - Otherwise next = c ± step toward t.
  - No overshoot, no wrap (e.g. c=C0, t=FF, s=40 gives FF).
- ACfgStep is sampled when leaving Idle and held for the whole burst.
- Config writes are accepted in any state. target[ACfgIdx] updates on the next clock.
  - A write to the entry being computed in the same clock does not affect that cycle's data; the new target applies from the next cycle.
- Reset asserted mid-burst returns to reset values immediately (asynchronously), with no bus completion.
- Peripheral index invariant: exactly one byte read precedes exactly 16 dword writes per successful frame.

Decomposition:
- Shared package led_seq_pkg:
  - State enum {Idle, Rst, Upd, Done, Abort}.
  - CLedCnt = 16.
  - Size codes CSizeD and CSizeB.
  - Colour channel width = 8.
- Sub-module led_fade_step: combinational per-channel step function (c, t, s -> next), instantiated 3 times on the selected entry.

Test Plan:
- Reset: hold AResetHN low 5 clocks -> all outputs 0, ABusy=0; after release with AEnable=0, no bus activity for 1000 clocks.
- Basic frame: CFramePeriod=64, target[3]=FF0000, step 40, immediate ack.
  - Frame 1: byte read at CAddrBase, then 16 writes; write #4 data=400000, others 000000; AFrameDone pulses.
  - Frames 2, 3 and 4: write #4 data=800000, C00000, FF0000.
  - Frame 5: FF0000 again.
- Decrease and step 0: current[0]=80FF20 after step 0 with target 80FF20. Then target=000000, step 30 -> next frame writes 50CF00.
- Ack latency: ack delayed 5 clocks per transaction -> bus signals held constant until ack, all 17 transactions complete, AErr=0.
- Timeout: withhold ack on the 7th write -> after 15 clocks AErr=1 and state returns to Idle with no AFrameDone; LEDs 0..5 updated, LED 6 unchanged. Next frame with normal acks clears AErr.
- Mid-burst: assert reset during write #10 -> outputs and tables zero immediately. Separately, a config write to the index in flight alters only the next frame's data.
